// File: rtl/vic_latch_wb.sv
// Vectored interrupt controller: latches edge/level requests, raises the CPU
// vectored-interrupt line and answers the acknowledge vector read, highest index first.
module vic_latch_wb #(
    parameter int unsigned  N            = 2,
    parameter logic [N-1:0] EDGE         = '1,
    parameter logic [15:0]  SPURIOUS_VEC = 16'o000000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic [15:0]     wb_dat_o,
    output logic            wb_irq_o,
    input  logic [16*N-1:0] ivec,
    input  logic [N-1:0]    ireq,
    output logic [N-1:0]    iack
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic [15:0]   dat_q, dat_d;
    logic          irq_q, irq_d;
    logic [N-1:0]  iack_q, iack_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  block_q, block_d;
    logic [N-1:0]  ireq_prev_q;

    logic [N-1:0]  eff_pend;
    logic [N-1:0]  serve_mask;
    logic [SW-1:0] sel;
    logic [15:0]   sel_vec;
    logic          serve;

    // Edge sources use the latch; level sources follow ireq until served, then stay masked.
    always_comb begin
        eff_pend = '0;
        for (int unsigned i = 0; i < N; i++) begin
            eff_pend[i] = EDGE[i] ? pending_q[i] : (ireq[i] & ~block_q[i]);
        end
    end

    // Ascending scan so the highest pending index is the one left in sel.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eff_pend[i]) begin
                sel = SW'(i);
            end
        end
    end

    always_comb begin
        sel_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                sel_vec = ivec[16*i +: 16];
            end
        end
    end

    assign serve = (state_q == S_IDLE) && wb_stb_i && (|eff_pend);

    always_comb begin
        serve_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            serve_mask[i] = serve && (sel == SW'(i));
        end
    end

    // A new edge in the serve cycle survives the clear.
    always_comb begin
        pending_d = '0;
        block_d   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                pending_d[i] = (ireq[i] & ~ireq_prev_q[i]) | (pending_q[i] & ~serve_mask[i]);
            end else begin
                block_d[i] = serve_mask[i] | (block_q[i] & ireq[i]);
            end
        end
    end

    assign irq_d = |(eff_pend & ~serve_mask);

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        iack_d  = '0;
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                dat_d = '0;
                if (wb_stb_i) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (serve) begin
                        dat_d  = sel_vec;
                        iack_d = serve_mask;
                    end else begin
                        dat_d = SPURIOUS_VEC;
                    end
                end
            end
            S_ACK: begin
                if (!wb_stb_i) begin
                    ack_d   = 1'b0;
                    dat_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                dat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            iack_q      <= '0;
            pending_q   <= '0;
            block_q     <= '0;
            ireq_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            iack_q      <= iack_d;
            pending_q   <= pending_d;
            block_q     <= block_d;
            ireq_prev_q <= ireq;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_irq_o = irq_q;
    assign iack     = iack_q;

endmodule

// File: tb/tb_vic_latch_wb.sv
// Bench for vic_latch_wb: per-cycle vector table on an all-edge instance with a
// read scoreboard, plus a hand sequence on an all-level instance.
module tb_vic_latch_wb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] IVEC = {16'o000060, 16'o000274};

    // edge-mode instance
    logic        e_rst, e_stb, e_ack, e_irq;
    logic [15:0] e_dat;
    logic [1:0]  e_ireq, e_iack;

    // level-mode instance
    logic        l_rst, l_stb, l_ack, l_irq;
    logic [15:0] l_dat;
    logic [1:0]  l_ireq, l_iack;

    vic_latch_wb #(.N(2), .EDGE(2'b11), .SPURIOUS_VEC(16'o000000)) u_edge (
        .wb_clk_i(clk), .wb_rst_i(e_rst), .wb_stb_i(e_stb), .wb_ack_o(e_ack),
        .wb_dat_o(e_dat), .wb_irq_o(e_irq), .ivec(IVEC), .ireq(e_ireq), .iack(e_iack)
    );

    vic_latch_wb #(.N(2), .EDGE(2'b00), .SPURIOUS_VEC(16'o000777)) u_lvl (
        .wb_clk_i(clk), .wb_rst_i(l_rst), .wb_stb_i(l_stb), .wb_ack_o(l_ack),
        .wb_dat_o(l_dat), .wb_irq_o(l_irq), .ivec(IVEC), .ireq(l_ireq), .iack(l_iack)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0o required %0o", nm, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        stb;
        logic [1:0]  ireq;
        logic        push;
        logic        ack;
        logic [15:0] dat;
        logic        irq;
        logic [1:0]  iack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic rst, input logic stb, input logic [1:0] ireq,
                                 input logic push, input logic ack, input logic [15:0] dat,
                                 input logic irq, input logic [1:0] iack);
        vec_t v;
        v.rst = rst; v.stb = stb; v.ireq = ireq; v.push = push;
        v.ack = ack; v.dat = dat; v.irq = irq; v.iack = iack;
        return v;
    endfunction

    // scoreboard of expected {dat, iack} per read, popped when ack rises
    logic [17:0] sb[$];
    logic        ack_prev = 1'b0;
    logic [17:0] sb_exp;

    always @(negedge clk) begin
        if (e_ack && !ack_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 32'(e_ack), 32'(0));
            end else begin
                sb_exp = sb.pop_front();
                chk("sb_dat", 32'(e_dat), 32'(sb_exp[17:2]));
                chk("sb_iack", 32'(e_iack), 32'(sb_exp[1:0]));
            end
        end
        ack_prev <= e_ack;
    end

    task automatic lstep(input string nm, input logic ack, input logic [15:0] dat,
                         input logic irq, input logic [1:0] iack);
        @(posedge clk); #1;
        chk({nm, "_ack"}, 32'(l_ack), 32'(ack));
        chk({nm, "_dat"}, 32'(l_dat), 32'(dat));
        chk({nm, "_irq"}, 32'(l_irq), 32'(irq));
        chk({nm, "_iack"}, 32'(l_iack), 32'(iack));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_rst = 1'b1; e_stb = 1'b0; e_ireq = 2'b11;
        l_rst = 1'b1; l_stb = 1'b0; l_ireq = 2'b00;

        //                rst   stb   ireq   push  ack   dat          irq   iack
        // reset with both requests held, then latch on release
        tbl.push_back(row(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 16'o000000, 1'b1, 2'b00));
        // two sequential reads, source 1 first
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'o000060, 1'b1, 2'b10));
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 16'o000060, 1'b1, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b1, 2'b00));
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'o000274, 1'b0, 2'b01));
        tbl.push_back(row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        // single-cycle pulse on source 0, one-cycle strobe
        tbl.push_back(row(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b1, 2'b00));
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'o000274, 1'b0, 2'b01));
        tbl.push_back(row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        // spurious read, new edge on the ack cycle still latched
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 16'o000000, 1'b1, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'o000000, 1'b1, 2'b00));
        // reset in ACK with strobe held, then spurious read from clean state
        tbl.push_back(row(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 16'o000060, 1'b1, 2'b10));
        tbl.push_back(row(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'o000000, 1'b0, 2'b00));
        tbl.push_back(row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000000, 1'b0, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            e_rst  = tbl[i].rst;
            e_stb  = tbl[i].stb;
            e_ireq = tbl[i].ireq;
            if (tbl[i].push) sb.push_back({tbl[i].dat, tbl[i].iack});
            @(posedge clk); #1;
            chk($sformatf("row%0d_ack", i), 32'(e_ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d_dat", i), 32'(e_dat), 32'(tbl[i].dat));
            chk($sformatf("row%0d_irq", i), 32'(e_irq), 32'(tbl[i].irq));
            chk($sformatf("row%0d_iack", i), 32'(e_iack), 32'(tbl[i].iack));
        end
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        // level source 1 held for three cycles after iack, then re-raised
        l_rst = 1'b0;                   lstep("lvl_idle", 1'b0, 16'o000000, 1'b0, 2'b00);
        l_ireq = 2'b10;                 lstep("lvl_req",  1'b0, 16'o000000, 1'b1, 2'b00);
        l_stb = 1'b1;                   lstep("lvl_read", 1'b1, 16'o000060, 1'b0, 2'b10);
        l_stb = 1'b0;                   lstep("lvl_hold1", 1'b0, 16'o000000, 1'b0, 2'b00);
                                        lstep("lvl_hold2", 1'b0, 16'o000000, 1'b0, 2'b00);
                                        lstep("lvl_hold3", 1'b0, 16'o000000, 1'b0, 2'b00);
        l_ireq = 2'b00;                 lstep("lvl_low",  1'b0, 16'o000000, 1'b0, 2'b00);
        l_ireq = 2'b10;                 lstep("lvl_rearm", 1'b0, 16'o000000, 1'b1, 2'b00);
        l_ireq = 2'b00; l_stb = 1'b1;   lstep("lvl_spur", 1'b1, 16'o000777, 1'b0, 2'b00);
        l_stb = 1'b0;                   lstep("lvl_end",  1'b0, 16'o000000, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
